window_accu: RTL and testbench

WINDOW_ACCU -- requirements
Module: window_accu

---
 rtl/window_accu_if.sv | 24 ++
 rtl/window_accu.sv | 134 +++++++++++++
 tb/tb_window_accu.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/window_accu_if.sv
// Sample/result bundle between a producer and window_accu.
// The producer drives en/din/din_valid/mode and observes dout/data_ready/busy.
interface window_accu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 37
);
    logic                         en;
    logic signed [DATA_WIDTH-1:0] din;
    logic                         din_valid;
    logic                         mode;
    logic signed [OUT_WIDTH-1:0]  dout;
    logic                         data_ready;
    logic                         busy;

    modport master (
        output en, din, din_valid, mode,
        input  dout, data_ready, busy
    );

    modport slave (
        input  en, din, din_valid, mode,
        output dout, data_ready, busy
    );
endinterface

// File: rtl/window_accu.sv
// Windowed accumulator: publishes either the sum of WIN_LEN samples or their
// line length (sum of saturated absolute sample-to-sample differences).
module window_accu #(
    parameter int DATA_WIDTH = 32,
    parameter int WIN_LEN    = 32,
    parameter int OUT_WIDTH  = 37
) (
    input logic          clk,
    input logic          rst,
    window_accu_if.slave bus
);

    localparam int                    CNT_W    = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(WIN_LEN - 1);
    localparam logic [DATA_WIDTH:0]   SAT_MAX  = {2'b00, {(DATA_WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic signed [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]  prev_q, prev_d;
    logic                          prev_valid_q, prev_valid_d;
    logic                          mode_q, mode_d;
    logic signed [OUT_WIDTH-1:0]   dout_q, dout_d;
    logic                          data_ready_q, data_ready_d;

    logic                          accept;
    logic                          first;
    logic                          last;
    logic                          eff_mode;
    logic signed [DATA_WIDTH:0]    diff;
    logic [DATA_WIDTH:0]           diff_u;
    logic [DATA_WIDTH:0]           mag;
    logic [DATA_WIDTH:0]           sat;
    logic signed [OUT_WIDTH-1:0]   term;

    // Sample 0 takes its mode straight from the input, since mode_q is only
    // loaded on that same edge.
    always_comb begin
        accept   = bus.din_valid && !bus.en;
        first    = (cnt_q == '0);
        last     = (cnt_q == LAST_IDX);
        eff_mode = first ? bus.mode : mode_q;

        diff   = {bus.din[DATA_WIDTH-1], bus.din} - {prev_q[DATA_WIDTH-1], prev_q};
        diff_u = diff;
        mag    = diff[DATA_WIDTH] ? (~diff_u + (DATA_WIDTH+1)'(1)) : diff_u;
        sat    = (mag > SAT_MAX) ? SAT_MAX : mag;

        term = '0;
        if (eff_mode) begin
            if (prev_valid_q) begin
                term = {{(OUT_WIDTH-DATA_WIDTH-1){1'b0}}, sat};
            end
        end else begin
            term = {{(OUT_WIDTH-DATA_WIDTH){bus.din[DATA_WIDTH-1]}}, bus.din};
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        mode_d       = mode_q;
        dout_d       = dout_q;
        data_ready_d = 1'b0;

        if (accept) begin
            prev_d       = bus.din;
            prev_valid_d = 1'b1;
            cnt_d        = cnt_q + CNT_W'(1);
            if (first) begin
                mode_d = bus.mode;
            end
            if (last) begin
                dout_d       = acc_q + term;
                acc_d        = '0;
                data_ready_d = 1'b1;
            end else begin
                acc_d = acc_q + term;
            end
        end

        // DONE is held while stalled so the return to IDLE happens once en drops.
        case (state_q)
            IDLE: begin
                if (accept) state_d = ACCUM;
            end
            ACCUM: begin
                if (accept && last) state_d = DONE;
            end
            DONE: begin
                if (bus.en)      state_d = DONE;
                else if (accept) state_d = ACCUM;
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            mode_q       <= 1'b0;
            dout_q       <= '0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            mode_q       <= mode_d;
            dout_q       <= dout_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.data_ready = data_ready_q;
    assign bus.busy       = (state_q == ACCUM);

endmodule

// File: tb/tb_window_accu.sv
// Self-checking bench for window_accu: table of whole windows, hand-written
// corner sequences and a randomized run, all checked every cycle against a model.
module tb_window_accu;

    localparam int DW = 32;
    localparam int WL = 32;
    localparam int OW = 37;

    localparam longint MIN_S = -64'sd2147483648;
    localparam longint MAX_S = 64'sd2147483647;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    window_accu_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

    window_accu #(
        .DATA_WIDTH(DW),
        .WIN_LEN   (WL),
        .OUT_WIDTH (OW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: the accepted samples of the open window, plus what was
    // known about the previous sample at the moment the window opened.
    longint win_samples[$];
    bit     win_mode;
    longint first_prev;
    bit     first_pv;
    longint m_prev;
    bit     m_pv;
    longint exp_dout;
    bit     exp_ready;

    typedef struct {
        bit     do_rst;
        bit     mode;
        longint base;
        longint step;
        longint exp_dout;
    } vec_t;

    function automatic longint sat_abs(longint a, longint b);
        longint d;
        d = a - b;
        if (d < 0) d = -d;
        if (d > MAX_S) d = MAX_S;
        return d;
    endfunction

    function automatic longint window_result();
        longint total;
        longint p;
        bit     pv;
        total = 0;
        p     = first_prev;
        pv    = first_pv;
        foreach (win_samples[i]) begin
            if (win_mode) begin
                if (pv) total += sat_abs(win_samples[i], p);
            end else begin
                total += win_samples[i];
            end
            p  = win_samples[i];
            pv = 1'b1;
        end
        return total;
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit v, input longint d, input bit m);
        if (r) begin
            win_samples.delete();
            m_prev    = 0;
            m_pv      = 1'b0;
            exp_dout  = 0;
            exp_ready = 1'b0;
        end else begin
            exp_ready = 1'b0;
            if (!e && v) begin
                if (win_samples.size() == 0) begin
                    win_mode   = m;
                    first_prev = m_prev;
                    first_pv   = m_pv;
                end
                win_samples.push_back(d);
                m_prev = d;
                m_pv   = 1'b1;
                if (win_samples.size() == WL) begin
                    exp_dout  = window_result();
                    exp_ready = 1'b1;
                    win_samples.delete();
                end
            end
        end
    endtask

    task automatic check_val(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput();
        check_val("dout", longint'(bus.dout), exp_dout);
        check_val("data_ready", longint'(bus.data_ready), longint'(exp_ready));
        check_val("busy", longint'(bus.busy), (win_samples.size() > 0) ? 1 : 0);
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit v, input longint d, input bit m);
        @(negedge clk);
        rst           = r;
        bus.en        = e;
        bus.din_valid = v;
        bus.din       = DW'(d);
        bus.mode      = m;
        @(posedge clk);
        model_edge(r, e, v, d, m);
        #1;
        checkOutput();
    endtask

    vec_t tbl[9];

    initial begin
        logic signed [31:0] r32;
        longint d;
        bit     r, e, v, m;

        tbl[0] = '{1'b1, 1'b0, 1,          0,  32};
        tbl[1] = '{1'b0, 1'b0, MIN_S,      0,  -64'sd68719476736};
        tbl[2] = '{1'b0, 1'b0, MAX_S,      0,  64'sd68719476704};
        tbl[3] = '{1'b0, 1'b0, 0,          1,  496};
        tbl[4] = '{1'b0, 1'b0, -100,       5,  -720};
        tbl[5] = '{1'b1, 1'b1, 0,          3,  93};
        tbl[6] = '{1'b0, 1'b1, 100,       -2,  69};
        tbl[7] = '{1'b0, 1'b1, MIN_S,      0,  MAX_S};
        tbl[8] = '{1'b0, 1'b0, 7,         -1,  -272};

        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        bus.mode      = 1'b0;
        exp_dout      = 0;
        exp_ready     = 1'b0;
        m_prev        = 0;
        m_pv          = 1'b0;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 55, 1);
        check_val("reset dout", longint'(bus.dout), 0);
        check_val("reset busy", longint'(bus.busy), 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Back-to-back windows: each window's sample 0 lands in the previous DONE cycle.
        for (int k = 0; k < 9; k++) begin
            if (tbl[k].do_rst) applyStimulus(1, 0, 0, 0, 0);
            for (int i = 0; i < WL; i++)
                applyStimulus(0, 0, 1, tbl[k].base + i * tbl[k].step, tbl[k].mode);
            check_val($sformatf("table[%0d] ready", k), longint'(bus.data_ready), 1);
            check_val($sformatf("table[%0d] dout", k), longint'(bus.dout), tbl[k].exp_dout);
        end
        applyStimulus(0, 0, 0, 0, 0);
        check_val("idle after table busy", longint'(bus.busy), 0);

        // Line length with invalid first prev: 0,10,4,4,...
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < WL; i++)
            applyStimulus(0, 0, 1, (i == 0) ? 0 : ((i == 1) ? 10 : 4), 1);
        check_val("linelen dout", longint'(bus.dout), 16);

        // Full-scale alternating steps saturate every term.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < WL; i++)
            applyStimulus(0, 0, 1, (i % 2 == 0) ? MIN_S : MAX_S, 1);
        check_val("saturate dout", longint'(bus.dout), 64'sd66571993057);

        // Five-cycle stall at sample 10 with junk on din.
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < WL; i++) begin
            if (i == 10)
                for (int s = 0; s < 5; s++) applyStimulus(0, 1, 1, 999, 1);
            applyStimulus(0, 0, 1, i, 0);
        end
        check_val("stall ready", longint'(bus.data_ready), 1);
        check_val("stall dout", longint'(bus.dout), 496);

        // Stall during the DONE cycle: pulse must still last one cycle.
        for (int i = 0; i < WL; i++) applyStimulus(0, 0, 1, 1, 0);
        check_val("done-stall first ready", longint'(bus.data_ready), 1);
        for (int s = 0; s < 3; s++) begin
            applyStimulus(0, 1, 1, 5, 0);
            check_val("done-stall ready low", longint'(bus.data_ready), 0);
            check_val("done-stall dout held", longint'(bus.dout), 32);
        end
        applyStimulus(0, 0, 0, 0, 0);
        check_val("done-stall idle busy", longint'(bus.busy), 0);

        // Abort at sample 20, then a clean window.
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 7, 0);
        applyStimulus(1, 0, 0, 0, 0);
        check_val("abort dout", longint'(bus.dout), 0);
        check_val("abort busy", longint'(bus.busy), 0);
        for (int i = 0; i < WL; i++) applyStimulus(0, 0, 1, 3, 0);
        check_val("after abort dout", longint'(bus.dout), 96);

        // Mode flips at sample 15: this window stays a sum, the next is line length.
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < WL; i++) applyStimulus(0, 0, 1, 2 * i, (i >= 15) ? 1'b1 : 1'b0);
        check_val("toggle window0 dout", longint'(bus.dout), 992);
        for (int i = 0; i < WL; i++) applyStimulus(0, 0, 1, 5, 1);
        check_val("toggle window1 dout", longint'(bus.dout), 57);

        // Randomized traffic with stalls, gaps, resets and extreme values.
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 249) == 0);
            e = ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: begin r32 = $urandom; d = longint'(r32); end
                1: d = longint'($urandom_range(0, 200)) - 100;
                2: d = MIN_S;
                default: d = MAX_S;
            endcase
            applyStimulus(r, e, v, d, m);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
